spi_xfer_sched: RTL

Multi-requester transfer scheduler that sits in front of spi_master and owns its configuration inputs (data_m, spcon, spibr, spssn).
It arbitrates byte-transfer requests round-robin, programs spi_master for the winning request and frames the slave select. It times the transfer by counting sck transitions, captures data_r_m, and returns it with a done pulse. A watchdog aborts transfers whose sck never completes.

---
 rtl/spi_xfer_sched.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_sched.sv
// Round-robin byte-transfer scheduler in front of spi_master: latches the winning
// request's fields, frames slave select, times the transfer from sck edges, returns data_r_m.
module spi_xfer_sched #(
  parameter int NREQ      = 4,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_tx,
  input  logic [NREQ*3-1:0] req_ss,
  input  logic [NREQ*2-1:0] req_mode,
  input  logic [NREQ*3-1:0] req_br,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rx_data,
  output logic              err,
  output logic              busy,
  output logic [7:0]        data_m,
  output logic [7:0]        spcon,
  output logic [7:0]        spibr,
  output logic [7:0]        spssn,
  input  logic [7:0]        data_r_m,
  input  logic              sck
);
  localparam int PW  = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [4:0]      tog_q, tog_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            sck_q;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      rx_data_q, rx_data_d, data_m_q, data_m_d;
  logic [7:0]      spcon_q, spcon_d, spibr_q, spibr_d, spssn_q, spssn_d;

  logic            latch_ev, start_ev, finish_ev, abort_ev, toggle;
  logic            win_found;
  logic [PW-1:0]   win_idx, rot_k;
  logic [PW:0]     win_sum;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0] req_rot;

  logic [7:0] tx_arr   [NREQ];
  logic [2:0] ss_arr   [NREQ];
  logic [1:0] mode_arr [NREQ];
  logic [2:0] br_arr   [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_fields
    assign tx_arr[gi]   = req_tx[8*gi +: 8];
    assign ss_arr[gi]   = req_ss[3*gi +: 3];
    assign mode_arr[gi] = req_mode[2*gi +: 2];
    assign br_arr[gi]   = req_br[3*gi +: 3];
  end

  // Rotate requests so bit 0 is the requester at ptr, then take the lowest set bit.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr_q +: NREQ];

  always_comb begin
    win_found = 1'b0;
    rot_k     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_found = 1'b1;
        rot_k     = PW'(k);
      end
    end
  end

  assign win_sum = {1'b0, ptr_q} + {1'b0, rot_k};
  assign win_idx = (win_sum >= (PW+1)'(NREQ)) ? PW'(win_sum - (PW+1)'(NREQ)) : PW'(win_sum);
  assign toggle  = (sck != sck_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      tog_q     <= '0;
      wd_q      <= '0;
      sck_q     <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rx_data_q <= '0;
      data_m_q  <= '0;
      spcon_q   <= '0;
      spibr_q   <= '0;
      spssn_q   <= 8'hff;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tog_q     <= tog_d;
      wd_q      <= wd_d;
      sck_q     <= sck;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rx_data_q <= rx_data_d;
      data_m_q  <= data_m_d;
      spcon_q   <= spcon_d;
      spibr_q   <= spibr_d;
      spssn_q   <= spssn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tog_d     = tog_q;
    wd_d      = wd_q;
    latch_ev  = 1'b0;
    start_ev  = 1'b0;
    finish_ev = 1'b0;
    abort_ev  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          latch_ev = 1'b1;
          ptr_d    = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 4'(SETUP_CYC - 1)) begin
          start_ev = 1'b1;
          cnt_d    = '0;
          tog_d    = '0;
          wd_d     = '0;
          state_d  = XFER;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      XFER: begin
        wd_d = wd_q + 1'b1;
        if (toggle && tog_q != 5'd16) tog_d = tog_q + 5'd1;
        // A completing toggle wins over the watchdog in the same cycle.
        if (toggle && tog_q == 5'd15) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          abort_ev = 1'b1;
          cnt_d    = '0;
          state_d  = GAP;
        end
      end
      HOLD: begin
        if (cnt_q == 4'(HOLD_CYC - 1)) begin
          finish_ev = 1'b1;
          cnt_d     = '0;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      GAP: begin
        if (cnt_q == 4'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = 1'b0;
    rx_data_d = rx_data_q;
    data_m_d  = data_m_q;
    spcon_d   = spcon_q;
    spibr_d   = spibr_q;
    spssn_d   = spssn_q;
    if (latch_ev) begin
      gnt_d    = NREQ'(1) << win_idx;
      data_m_d = tx_arr[win_idx];
      spibr_d  = {5'b0, br_arr[win_idx]};
      spcon_d  = {4'b0, mode_arr[win_idx], 2'b0};
      spssn_d  = ~(8'd1 << ss_arr[win_idx]);
    end
    if (start_ev) spcon_d[6] = 1'b1;
    if (finish_ev || abort_ev) begin
      done_d  = gnt_q;
      err_d   = abort_ev;
      gnt_d   = '0;
      spcon_d = '0;
      spssn_d = 8'hff;
      if (finish_ev) rx_data_d = data_r_m;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rx_data = rx_data_q;
  assign data_m  = data_m_q;
  assign spcon   = spcon_q;
  assign spibr   = spibr_q;
  assign spssn   = spssn_q;
  assign busy    = (state_q != IDLE);

endmodule
